// File: rtl/riffa_tx_packer.sv
// Response packer: buffers executor words in a show-ahead FIFO and emits them
// as self-contained RIFFA TX transactions of up to C_MAX_BURST beats.
module riffa_tx_packer #(
  parameter int C_PCI_DATA_WIDTH = 64,
  parameter int C_DEPTH          = 16,
  parameter int C_MAX_BURST      = 8,
  parameter int C_FLUSH_TIMEOUT  = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [C_PCI_DATA_WIDTH-1:0] in_data,
  input  logic                        in_last,
  output logic [$clog2(C_DEPTH):0]    fill_level,
  output logic                        CHNL_TX_CLK,
  output logic                        CHNL_TX,
  input  logic                        CHNL_TX_ACK,
  output logic                        CHNL_TX_LAST,
  output logic [31:0]                 CHNL_TX_LEN,
  output logic [30:0]                 CHNL_TX_OFF,
  output logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
  output logic                        CHNL_TX_DATA_VALID,
  input  logic                        CHNL_TX_DATA_REN
);
  localparam int AW = $clog2(C_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(C_MAX_BURST) + 1;
  localparam int TW = (C_FLUSH_TIMEOUT > 0) ? $clog2(C_FLUSH_TIMEOUT + 1) : 1;
  localparam int WORDS_PER_BEAT = C_PCI_DATA_WIDTH / 32;

  typedef enum logic [1:0] {IDLE, REQ, SEND, DONE} state_t;

  logic [C_PCI_DATA_WIDTH-1:0] mem [C_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [BW-1:0] beats, n_burst, n_next;
  logic [TW-1:0] timer;
  logic          flush_req;
  state_t        state;
  logic          tx_q, valid_q;
  logic [31:0]   len_q, len_next;
  logic          push, pop;
  logic          has_data, burst_ready, timed_out, start_idle, start_done;

  always_comb begin
    in_ready    = ~rst & (count < CW'(C_DEPTH));
    push        = in_valid & in_ready;
    pop         = valid_q & CHNL_TX_DATA_REN;
    has_data    = (count != '0);
    burst_ready = (count >= CW'(C_MAX_BURST));
    timed_out   = (timer == TW'(C_FLUSH_TIMEOUT));
    start_idle  = has_data & (burst_ready | flush_req | timed_out);
    // Timer is always zero in DONE, so only the burst/flush triggers apply there.
    start_done  = has_data & (burst_ready | flush_req);
    n_next      = burst_ready ? BW'(C_MAX_BURST) : BW'(count);
    len_next    = 32'(n_next) * 32'(WORDS_PER_BEAT);
  end

  assign fill_level         = count;
  assign CHNL_TX_CLK        = clk;
  assign CHNL_TX            = tx_q;
  assign CHNL_TX_LAST       = 1'b1;
  assign CHNL_TX_LEN        = len_q;
  assign CHNL_TX_OFF        = '0;
  assign CHNL_TX_DATA       = mem[rd_ptr];
  assign CHNL_TX_DATA_VALID = valid_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      beats     <= '0;
      n_burst   <= '0;
      timer     <= '0;
      flush_req <= 1'b0;
      state     <= IDLE;
      tx_q      <= 1'b0;
      valid_q   <= 1'b0;
      len_q     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (push && in_last)
        flush_req <= 1'b1;
      else if (state == DONE && count == '0)
        flush_req <= 1'b0;

      if (state != IDLE || !has_data || push || start_idle)
        timer <= '0;
      else if (!timed_out)
        timer <= timer + 1'b1;

      case (state)
        IDLE: begin
          if (start_idle) begin
            state   <= REQ;
            n_burst <= n_next;
            beats   <= '0;
            len_q   <= len_next;
            tx_q    <= 1'b1;
          end
        end
        REQ: begin
          if (CHNL_TX_ACK) begin
            state   <= SEND;
            valid_q <= 1'b1;
          end
        end
        SEND: begin
          if (pop) begin
            beats <= beats + 1'b1;
            if (beats == n_burst - 1'b1) begin
              state   <= DONE;
              valid_q <= 1'b0;
              tx_q    <= 1'b0;
              len_q   <= '0;
            end
          end
        end
        DONE: begin
          // Re-arm straight from DONE so back-to-back bursts see a single low cycle.
          if (start_done) begin
            state   <= REQ;
            n_burst <= n_next;
            beats   <= '0;
            len_q   <= len_next;
            tx_q    <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
